q2_i2c_target: RTL and testbench

Q2_I2C_TARGET -- requirements
Module: q2_i2c_target

---
 rtl/q2_i2c_target_pkg.sv | 21 ++
 rtl/q2_i2c_fifo.sv | 51 +++++
 rtl/q2_i2c_target.sv | 193 +++++++++++++++++++
 tb/tb_q2_i2c_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/q2_i2c_target_pkg.sv
// Shared definitions for the q2 I2C target: controller states and the
// bit positions of the status fields returned on dbus during a CPU read.
package q2_i2c_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX,
      ST_RX_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_IGNORE
   } state_e;

   localparam int DB_NOT_EMPTY = 8;
   localparam int DB_OVERFLOW  = 9;
   localparam int DB_BUSY      = 10;
   localparam int DB_MARKER    = 11;

endpackage

// File: rtl/q2_i2c_fifo.sv
// Receive FIFO for the I2C target: power-of-two depth, head visible without
// popping, push on full and pop on empty are ignored.
module q2_i2c_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // NOTE: storage is not reset; the count guards every read of stale entries.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/q2_i2c_target.sv
// I2C target with a receive FIFO and a single transmit byte register, both
// reached over a tri-state CPU bus that returns FIFO head plus status on rd.
module q2_i2c_target
   import q2_i2c_target_pkg::*;
#(
   parameter logic [6:0] ADDR  = 7'h50,
   parameter int         DEPTH = 4,
   parameter int         BUS_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   input  logic             rd,
   input  logic             wr,
   inout  wire [BUS_W-1:0]  dbus
);

   // [0],[1] synchronise; [2] is the previous synchronised value for edges.
   logic [2:0] scl_sync_q, sda_sync_q;
   logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   state_e     state_q;
   logic [3:0] bit_cnt_q;
   logic [6:0] shift_q;
   logic [7:0] tx_shift_q, tx_byte_q, push_data_q;
   logic       sda_oe_q, ack_q, phase_q, rw_q, push_q, ovf_q;
   logic [7:0] rx_byte;

   logic [7:0]       fifo_head;
   logic             fifo_empty, fifo_full;
   logic [BUS_W-1:0] status;
   logic             unused_dbus_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_in};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_s & ~scl_sync_q[2];
   assign scl_fall  = ~scl_s &  scl_sync_q[2];
   assign start_det = scl_s & scl_sync_q[2] &  sda_sync_q[2] & ~sda_s;
   assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] &  sda_s;
   assign rx_byte   = {shift_q, sda_s};

   always_ff @(posedge clk) begin
      if (!rst_n) tx_byte_q <= 8'hFF;
      else if (wr) tx_byte_q <= dbus[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sda_oe_q    <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_shift_q  <= 8'hFF;
         ack_q       <= 1'b0;
         phase_q     <= 1'b0;
         rw_q        <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (rd) ovf_q <= 1'b0;
         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            phase_q   <= 1'b0;
         end else if (stop_det) begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            phase_q  <= 1'b0;
         end else begin
            unique case (state_q)
               ST_ADDR, ST_RX: begin
                  if (scl_rise) begin
                     shift_q   <= rx_byte[6:0];
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        if (state_q == ST_ADDR) begin
                           rw_q    <= rx_byte[0];
                           ack_q   <= 1'b1;
                           state_q <= (rx_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end else begin
                           state_q <= ST_RX_ACK;
                           if (!fifo_full) begin
                              push_q      <= 1'b1;
                              push_data_q <= rx_byte;
                              ack_q       <= 1'b1;
                           end else begin
                              ovf_q <= 1'b1;
                              ack_q <= 1'b0;
                           end
                        end
                     end
                  end
               end
               // First fall opens the ACK slot, second fall closes it.
               ST_ADDR_ACK, ST_RX_ACK: begin
                  if (scl_fall) begin
                     if (!phase_q) begin
                        phase_q  <= 1'b1;
                        sda_oe_q <= ack_q;
                     end else begin
                        phase_q <= 1'b0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                           state_q    <= ST_TX;
                           tx_shift_q <= tx_byte_q;
                           sda_oe_q   <= ~tx_byte_q[7];
                           bit_cnt_q  <= '0;
                        end else begin
                           state_q  <= ST_RX;
                           sda_oe_q <= 1'b0;
                        end
                     end
                  end
               end
               ST_TX: begin
                  if (scl_rise) bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        state_q   <= ST_TX_ACK;
                     end else begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        sda_oe_q   <= ~tx_shift_q[6];
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s) phase_q <= 1'b1;
                     else        state_q <= ST_IGNORE;
                  end else if (scl_fall && phase_q) begin
                     phase_q    <= 1'b0;
                     state_q    <= ST_TX;
                     tx_shift_q <= tx_byte_q;
                     sda_oe_q   <= ~tx_byte_q[7];
                     bit_cnt_q  <= '0;
                  end
               end
               ST_IDLE, ST_IGNORE: sda_oe_q <= 1'b0;
               default: begin
                  state_q  <= ST_IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // NOTE: gating with rst_n releases SDA in the very cycle reset is asserted.
   assign sda_oe = sda_oe_q & rst_n;

   q2_i2c_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_q),
      .data_i  (push_data_q),
      .pop_i   (rd),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      status               = '0;
      status[7:0]          = fifo_empty ? 8'h00 : fifo_head;
      status[DB_NOT_EMPTY] = ~fifo_empty;
      status[DB_OVERFLOW]  = ovf_q;
      status[DB_BUSY]      = (state_q != ST_IDLE);
      status[DB_MARKER]    = 1'b1;
   end

   assign dbus           = rd ? status : {BUS_W{1'bz}};
   assign unused_dbus_hi = ^dbus[BUS_W-1:8];

endmodule

// File: tb/tb_q2_i2c_target.sv
// Directed bench for q2_i2c_target: a bit-banged I2C master with an
// open-drain SDA model, plus CPU rd/wr strobes on the shared bus.
module tb_q2_i2c_target;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst_n, scl_m, sda_m, rd, wr, drv_en;
   logic [11:0] drv_val;
   logic        sda_oe, sda_line;
   wire  [11:0] dbus;

   int n_checks = 0;
   int n_fail   = 0;
   int oe_hi_cnt = 0;
   int oe_base;

   logic        ack, s;
   logic [7:0]  rx;
   logic [11:0] st;

   always #5 clk = ~clk;

   assign dbus     = drv_en ? drv_val : 12'hzzz;
   assign sda_line = sda_m & ~sda_oe;

   always @(posedge clk) if (sda_oe) oe_hi_cnt <= oe_hi_cnt + 1;

   q2_i2c_target dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .scl_in (scl_m),
      .sda_in (sda_line),
      .sda_oe (sda_oe),
      .rd     (rd),
      .wr     (wr),
      .dbus   (dbus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic clk_bit(input logic b, output logic seen);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q();
      seen = sda_line;
      wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic a);
      logic x;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], x);
      clk_bit(1'b1, x);
      a = ~x;
   endtask

   task automatic recv_byte(input logic m_ack, output logic [7:0] d);
      logic x;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, x);
         d = {d[6:0], x};
      end
      clk_bit(~m_ack, x);
   endtask

   task automatic do_rd(output logic [11:0] v);
      @(negedge clk);
      rd = 1'b1;
      #1 v = dbus;
      @(posedge clk);
      #1 rd = 1'b0;
   endtask

   task automatic do_wr(input logic [7:0] b);
      @(negedge clk);
      drv_val = {4'h0, b};
      drv_en  = 1'b1;
      wr      = 1'b1;
      @(posedge clk);
      #1 wr = 1'b0;
      drv_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      rd = 1'b0; wr = 1'b0; drv_en = 1'b0; drv_val = '0;
      repeat (3) @(negedge clk);
      check("reset_sda_oe", 32'(sda_oe), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      do_rd(st);
      check("reset_status", 32'(st), 32'h800);

      // Write 0x12, 0x34 to our address, then pop both.
      i2c_start();
      send_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'd1);
      send_byte(8'h12, ack); check("w_d0_ack", 32'(ack), 32'd1);
      send_byte(8'h34, ack); check("w_d1_ack", 32'(ack), 32'd1);
      i2c_stop();
      do_rd(st); check("w_pop0", 32'(st), 32'h912);
      do_rd(st); check("w_pop1", 32'(st), 32'h934);
      do_rd(st); check("w_empty", 32'(st), 32'h800);

      // Foreign address 0x51: never driven, block busy until STOP.
      oe_base = oe_hi_cnt;
      i2c_start();
      send_byte(8'hA2, ack); check("bad_addr_nack", 32'(ack), 32'd0);
      do_rd(st); check("bad_ignore_busy", 32'(st), 32'hC00);
      send_byte(8'h11, ack); check("bad_data_nack", 32'(ack), 32'd0);
      i2c_stop();
      check("bad_oe_never", 32'(oe_hi_cnt - oe_base), 32'd0);
      do_rd(st); check("bad_fifo_empty", 32'(st), 32'h800);

      // Read 0x5A twice, NACK, then the block must stay silent.
      do_wr(8'h5A);
      i2c_start();
      send_byte(8'hA1, ack); check("r_addr_ack", 32'(ack), 32'd1);
      recv_byte(1'b1, rx);   check("r_byte0", 32'(rx), 32'h5A);
      recv_byte(1'b0, rx);   check("r_byte1", 32'(rx), 32'h5A);
      do_rd(st); check("r_ignore_busy", 32'(st), 32'hC00);
      oe_base = oe_hi_cnt;
      recv_byte(1'b0, rx);   check("r_ignored_byte", 32'(rx), 32'hFF);
      check("r_ignored_oe", 32'(oe_hi_cnt - oe_base), 32'd0);
      i2c_stop();
      do_rd(st); check("r_idle", 32'(st), 32'h800);

      // Overflow: six bytes into a four-entry FIFO.
      i2c_start();
      send_byte(8'hA0, ack); check("ov_addr_ack", 32'(ack), 32'd1);
      send_byte(8'h01, ack); check("ov_ack1", 32'(ack), 32'd1);
      send_byte(8'h02, ack); check("ov_ack2", 32'(ack), 32'd1);
      send_byte(8'h03, ack); check("ov_ack3", 32'(ack), 32'd1);
      send_byte(8'h04, ack); check("ov_ack4", 32'(ack), 32'd1);
      send_byte(8'h05, ack); check("ov_nack5", 32'(ack), 32'd0);
      send_byte(8'h06, ack); check("ov_nack6", 32'(ack), 32'd0);
      i2c_stop();
      do_rd(st); check("ov_pop1", 32'(st), 32'hB01);
      do_rd(st); check("ov_pop2_clr", 32'(st), 32'h902);
      do_rd(st); check("ov_pop3", 32'(st), 32'h903);
      do_rd(st); check("ov_pop4", 32'(st), 32'h904);
      do_rd(st); check("ov_empty", 32'(st), 32'h800);

      // Repeated START after three data bits.
      i2c_start();
      send_byte(8'hA0, ack); check("rs_addr0_ack", 32'(ack), 32'd1);
      for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
      i2c_start();
      send_byte(8'hA0, ack); check("rs_addr1_ack", 32'(ack), 32'd1);
      send_byte(8'h77, ack); check("rs_data_ack", 32'(ack), 32'd1);
      i2c_stop();
      do_rd(st); check("rs_pop", 32'(st), 32'h977);
      do_rd(st); check("rs_empty", 32'(st), 32'h800);

      // Reset in the address ACK slot; later bytes without START are ignored.
      i2c_start();
      for (int i = 7; i >= 0; i--) clk_bit(((8'hA0 >> i) & 8'h01) != 0, s);
      sda_m = 1'b1;
      wait_q();
      check("rst_ack_driven", 32'(sda_oe), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("rst_same_cycle", 32'(sda_oe), 32'd0);
      @(posedge clk);
      #1 check("rst_next_clk", 32'(sda_oe), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
      oe_base = oe_hi_cnt;
      send_byte(8'hA0, ack); check("rst_no_start_nack", 32'(ack), 32'd0);
      check("rst_no_start_oe", 32'(oe_hi_cnt - oe_base), 32'd0);
      do_rd(st); check("rst_idle", 32'(st), 32'h800);
      i2c_stop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
